// File: rtl/config_usb_pkg.sv
// Shared types and constants for the CDC configuration readback transmitter.
// Holds the framing FSM states and the byte-selection helper used by the top.
package config_usb_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        COUNT,
        PAYLOAD,
        CHECKSUM,
        DONE
    } state_t;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [31:0] w,
                                                    input logic [IDX_W-1:0] idx);
        word_byte = w[(WORD_BYTES - 1 - int'(idx)) * BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Holds one readback word and hands it out MSB byte first, folding every
// byte that leaves into a running XOR checksum.
module config_word_serializer
    import config_usb_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [31:0]       word_i,
    input  logic              shift_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              buf_full_o,
    output logic              last_byte_o,
    output logic [BYTE_W-1:0] checksum_o
);

    logic [31:0]       buf_q;
    logic [IDX_W-1:0]  idx_q;
    logic              full_q;
    logic [BYTE_W-1:0] csum_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            csum_q <= '0;
        end else begin
            if (clear_i)
                csum_q <= '0;
            else if (shift_i)
                csum_q <= csum_q ^ buf_q[31:24];

            if (load_i) begin
                buf_q  <= word_i;
                idx_q  <= '0;
                full_q <= 1'b1;
            end else if (shift_i) begin
                buf_q <= {buf_q[23:0], 8'h00};
                if (last_byte_o) begin
                    idx_q  <= '0;
                    full_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign byte_o      = buf_q[31:24];
    assign buf_full_o  = full_q;
    assign last_byte_o = (idx_q == IDX_W'(WORD_BYTES - 1));
    assign checksum_o  = csum_q;

endmodule

// File: rtl/config_readback_tx.sv
// Frames configuration readback words into the CDC IN byte stream:
// sync word, 16-bit word count, payload words MSB first, XOR checksum.
module config_readback_tx
    import config_usb_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] word_count_i,
    input  logic [31:0]        word_data_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    output logic [BYTE_W-1:0]  in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    state_t             state_q;
    logic [IDX_W-1:0]   byteIdx_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] wordsLeft_q;
    logic               busy_q;
    logic               done_q;

    logic               startAccept;
    logic               byteXfer;
    logic               wordLoad;
    logic               payloadShift;
    logic               serFull;
    logic               serLast;
    logic [BYTE_W-1:0]  serByte;
    logic [BYTE_W-1:0]  checksum;
    logic [15:0]        countField;

    assign startAccept  = (state_q == IDLE) && start_i;
    assign byteXfer     = in_valid_o && in_ready_i;
    assign word_ready_o = (state_q == PAYLOAD) && !serFull && (wordsLeft_q != '0);
    assign wordLoad     = word_valid_i && word_ready_o;
    assign payloadShift = (state_q == PAYLOAD) && byteXfer;
    assign countField   = 16'(count_q);

    config_word_serializer u_serializer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (startAccept),
        .load_i      (wordLoad),
        .word_i      (word_data_i),
        .shift_i     (payloadShift),
        .byte_o      (serByte),
        .buf_full_o  (serFull),
        .last_byte_o (serLast),
        .checksum_o  (checksum)
    );

    // The byte lane depends on registered state only, never on in_ready_i.
    always_comb begin
        in_valid_o = 1'b0;
        in_data_o  = '0;
        unique case (state_q)
            SYNC: begin
                in_valid_o = 1'b1;
                in_data_o  = word_byte(SYNC_WORD, byteIdx_q);
            end
            COUNT: begin
                in_valid_o = 1'b1;
                in_data_o  = byteIdx_q[0] ? countField[7:0] : countField[15:8];
            end
            PAYLOAD: begin
                in_valid_o = serFull;
                in_data_o  = serByte;
            end
            CHECKSUM: begin
                in_valid_o = 1'b1;
                in_data_o  = checksum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            byteIdx_q   <= '0;
            count_q     <= '0;
            wordsLeft_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        count_q     <= word_count_i;
                        wordsLeft_q <= word_count_i;
                        byteIdx_q   <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SYNC;
                    end
                end
                SYNC: begin
                    if (byteXfer) begin
                        if (byteIdx_q == IDX_W'(WORD_BYTES - 1)) begin
                            byteIdx_q <= '0;
                            state_q   <= COUNT;
                        end else begin
                            byteIdx_q <= byteIdx_q + 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (byteXfer) begin
                        if (byteIdx_q[0]) begin
                            byteIdx_q <= '0;
                            state_q   <= (count_q != '0) ? PAYLOAD : CHECKSUM;
                        end else begin
                            byteIdx_q <= byteIdx_q + 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byteXfer && serLast) begin
                        wordsLeft_q <= wordsLeft_q - 1'b1;
                        if (wordsLeft_q == COUNT_W'(1))
                            state_q <= CHECKSUM;
                    end
                end
                CHECKSUM: begin
                    if (byteXfer) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_config_readback_tx.sv
// Directed bench for config_readback_tx: checks reset, framing, checksum,
// backpressure stability, source starvation and reset recovery.
module tb_config_readback_tx;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        start = 1'b0;
    logic [15:0] wordCount = 16'd0;
    logic [31:0] wordData = 32'd0;
    logic        wordValid = 1'b0;
    logic        wordReady;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady = 1'b1;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [7:0] bytesSeen[$];
    int         doneCnt = 0;
    int         stallCnt = 0;
    int         stallErrs = 0;
    bit         readySeen = 1'b0;
    bit         stallPend = 1'b0;
    logic [7:0] stallData = 8'h00;
    bit         togEn = 1'b0;
    int         togCnt = 0;

    always #5 clk = ~clk;

    config_readback_tx dut (
        .clk_i        (clk),
        .reset_n_i    (resetN),
        .start_i      (start),
        .word_count_i (wordCount),
        .word_data_i  (wordData),
        .word_valid_i (wordValid),
        .word_ready_o (wordReady),
        .in_data_o    (inData),
        .in_valid_o   (inValid),
        .in_ready_i   (inReady),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Inputs change 2 time units after a rising edge, so the falling edge
    // sees the values that the next rising edge will act on.
    always @(negedge clk) begin
        if (!resetN) begin
            stallPend = 1'b0;
        end else begin
            if (stallPend && (inValid !== 1'b1 || inData !== stallData))
                stallErrs++;
            if (inValid && inReady)
                bytesSeen.push_back(inData);
            stallPend = inValid && !inReady;
            if (stallPend) begin
                stallData = inData;
                stallCnt++;
            end
            if (done === 1'b1)
                doneCnt++;
            if (wordReady === 1'b1)
                readySeen = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        if (togEn) begin
            togCnt++;
            if (togCnt == 5) begin
                togCnt  = 0;
                inReady = ~inReady;
            end
        end
    end

    task automatic clear_mon();
        bytesSeen.delete();
        doneCnt   = 0;
        stallCnt  = 0;
        stallErrs = 0;
        readySeen = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] n);
        @(posedge clk);
        #2;
        start     = 1'b1;
        wordCount = n;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] w);
        wordData  = w;
        wordValid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wordReady === 1'b1) begin
                @(posedge clk);
                #2;
                break;
            end
        end
        wordValid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && doneCnt == 0; i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #13;
        resetN = 1'b0;
        #1;
        tests++;
        if ({inValid, wordReady, busy, done} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_immediate: got %b expected 0000", {inValid, wordReady, busy, done});
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if ({inValid, wordReady, busy, done} !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b expected 0000", c, {inValid, wordReady, busy, done});
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp [11] = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h01,
                                 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        clear_mon();
        inReady = 1'b1;
        start_frame(16'd1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_busy_start: got %b expected 1", busy);
        end
        feed_word(32'h12345678);
        wait_done();
        tests++;
        if (bytesSeen.size() != 11) begin
            fails++;
            $display("[TB] FAIL single_len: got %0d expected 11", bytesSeen.size());
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (i >= bytesSeen.size() || bytesSeen[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL single_byte %0d: got %02h expected %02h", i,
                         (i < bytesSeen.size()) ? bytesSeen[i] : 8'hxx, exp[i]);
            end
        end
        tests++;
        if (doneCnt != 1) begin
            fails++;
            $display("[TB] FAIL single_done: got %0d pulses expected 1", doneCnt);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] exp [7] = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h00, 8'h00};
        clear_mon();
        start_frame(16'd0);
        wait_done();
        tests++;
        if (bytesSeen.size() != 7) begin
            fails++;
            $display("[TB] FAIL zero_len: got %0d expected 7", bytesSeen.size());
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (i >= bytesSeen.size() || bytesSeen[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL zero_byte %0d: got %02h expected %02h", i,
                         (i < bytesSeen.size()) ? bytesSeen[i] : 8'hxx, exp[i]);
            end
        end
        tests++;
        if (readySeen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_word_ready: got %b expected 0", readySeen);
        end
        tests++;
        if (doneCnt != 1) begin
            fails++;
            $display("[TB] FAIL zero_done: got %0d pulses expected 1", doneCnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [15] = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h02,
                                 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        clear_mon();
        inReady = 1'b1;
        togCnt  = 0;
        togEn   = 1'b1;
        start_frame(16'd2);
        feed_word(32'hDEADBEEF);
        feed_word(32'h01020304);
        wait_done();
        togEn   = 1'b0;
        @(posedge clk);
        #2;
        inReady = 1'b1;
        tests++;
        if (bytesSeen.size() != 15) begin
            fails++;
            $display("[TB] FAIL bp_len: got %0d expected 15", bytesSeen.size());
        end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (i >= bytesSeen.size() || bytesSeen[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL bp_byte %0d: got %02h expected %02h", i,
                         (i < bytesSeen.size()) ? bytesSeen[i] : 8'hxx, exp[i]);
            end
        end
        tests++;
        if (stallCnt == 0) begin
            fails++;
            $display("[TB] FAIL bp_stalls: got %0d stall cycles expected >0", stallCnt);
        end
        tests++;
        if (stallErrs != 0) begin
            fails++;
            $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", stallErrs);
        end
        tests++;
        if (doneCnt != 1) begin
            fails++;
            $display("[TB] FAIL bp_done: got %0d pulses expected 1", doneCnt);
        end
    endtask

    task automatic test_starvation();
        logic [7:0] exp [15] = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h02,
                                 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        clear_mon();
        start_frame(16'd2);
        feed_word(32'h11223344);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            start     = (c == 8);
            wordCount = (c == 8) ? 16'd5 : 16'd2;
            if (c == 12) begin
                tests++;
                if ({inValid, wordReady, busy} !== 3'b011) begin
                    fails++;
                    $display("[TB] FAIL starve_gap: got valid/ready/busy %b expected 011", {inValid, wordReady, busy});
                end
            end
        end
        feed_word(32'h55667788);
        wait_done();
        tests++;
        if (bytesSeen.size() != 15) begin
            fails++;
            $display("[TB] FAIL starve_len: got %0d expected 15", bytesSeen.size());
        end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (i >= bytesSeen.size() || bytesSeen[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL starve_byte %0d: got %02h expected %02h", i,
                         (i < bytesSeen.size()) ? bytesSeen[i] : 8'hxx, exp[i]);
            end
        end
        tests++;
        if (doneCnt != 1) begin
            fails++;
            $display("[TB] FAIL starve_done: got %0d pulses expected 1", doneCnt);
        end
    endtask

    task automatic test_reset_mid_payload();
        logic [7:0] exp [11] = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h00, 8'h01,
                                 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        clear_mon();
        start_frame(16'd3);
        feed_word(32'hAABBCCDD);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        tests++;
        if ({inValid, wordReady, busy, done} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got %b expected 0000", {inValid, wordReady, busy, done});
        end
        @(posedge clk);
        #2;
        resetN = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk);
        tests++;
        if (bytesSeen.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_residual: got %0d bytes busy %b expected 0 bytes busy 0", bytesSeen.size(), busy);
        end
        start_frame(16'd1);
        feed_word(32'h000000FF);
        wait_done();
        tests++;
        if (bytesSeen.size() != 11) begin
            fails++;
            $display("[TB] FAIL fresh_len: got %0d expected 11", bytesSeen.size());
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (i >= bytesSeen.size() || bytesSeen[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL fresh_byte %0d: got %02h expected %02h", i,
                         (i < bytesSeen.size()) ? bytesSeen[i] : 8'hxx, exp[i]);
            end
        end
        tests++;
        if (doneCnt != 1) begin
            fails++;
            $display("[TB] FAIL fresh_done: got %0d pulses expected 1", doneCnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_count();
        test_backpressure();
        test_starvation();
        test_reset_mid_payload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
